vga_fb_arbiter: RTL and testbench
=================================

Name: vga_fb_arbiter

Overview:
- Shares one single-port synchronous framebuffer RAM (12-bit RGB, 640x480) between display scanout and two pixel writers (game logic / player objects).
- Sits between the VGA timing core and the RAM.
- Scanout owns the RAM every active-video cycle. Writers are granted round-robin only inside the blanking window.
- Also delays sync/video_on to match the 1-cycle RAM read latency, and emits a per-frame tick for game-state updates.

Parameters:
- HD, 640, active pixels per line
- VD, 480, active lines per frame
- AW, 19, RAM address width (must satisfy 2^AW >= HD*VD)
- DW, 12, pixel data width

Ports:
- clk  in  1  pixel clock (25 MHz)
- rst  in  1  asynchronous reset, active-high
- pixel_x  in  12  current column from timing core
- pixel_y  in  12  current row from timing core
- video_on  in  1  active-video flag from timing core
- hsync  in  1  from timing core
- vsync  in  1  from timing core
- hsync_o  out  1  hsync delayed 1 clk
- vsync_o  out  1  vsync delayed 1 clk
- video_on_o  out  1  video_on delayed 1 clk
- rgb  out  DW  pixel to DAC
- frame_tick  out  1  1-clk pulse at start of vertical blank
- w0_req  in  1  writer 0 request
- w0_addr  in  AW  writer 0 address
- w0_data  in  DW  writer 0 data
- w0_gnt  out  1  writer 0 accepted this cycle
- w1_req  in  1  writer 1 request
- w1_addr  in  AW  writer 1 address
- w1_data  in  DW  writer 1 data
- w1_gnt  out  1  writer 1 accepted this cycle
- ram_addr  out  AW  RAM address
- ram_we  out  1  RAM write enable
- ram_wdata  out  DW  RAM write data
- ram_rdata  in  DW  RAM read data (valid 1 clk after address)

Behaviour:
- Reset (async, rst=1): scan_addr=0, rr_last=1 (writer 0 wins first tie), frame_tick=0, hsync_o=1, vsync_o=1, video_on_o=0. While rst=1: gnt=0, ram_we=0, rgb=0.
- Phase decode (combinational from inputs):
  - ACTIVE: video_on=1.
  - HBLANK: video_on=0 and pixel_y<VD.
  - VBLANK: pixel_y>=VD.
- Scan address:
  - In ACTIVE: ram_addr=scan_addr, ram_we=0, and scan_addr<=scan_addr+1.
  - Any cycle with pixel_y>=VD: scan_addr<=0.
  - Result: pixel (x,y) reads address y*HD+x. No multiplier is used.
- Output path:
  - hsync_o, vsync_o and video_on_o are registered copies of their inputs (1-clk latency).
  - rgb = video_on_o ? ram_rdata : 0 (combinational).
  - rgb is therefore aligned with hsync_o/vsync_o.
- Write window = not ACTIVE (base build).
- Arbitration (combinational grant, same cycle as req), in window:
  - Only one req: that writer is granted.
  - Both reqs: the writer not equal to rr_last is granted. rr_last<=granted id.
  - No req: ram_we=0, ram_addr=scan_addr.
- Granted writer drives the RAM: ram_addr=wX_addr, ram_wdata=wX_data, ram_we=1.
- Out-of-range address (wX_addr >= HD*VD): gnt still pulses (request consumed), but ram_we=0.
- Handshake:
  - Requester holds req/addr/data stable until it sees gnt=1 on a rising edge.
  - A requester may keep req high for back-to-back writes; each gnt consumes one write.
  - Outside the window, gnt=0 and requests wait. No timeout.
- Fairness: with both requesting continuously in a window, grants alternate 0,1,0,1. Worst-case wait = one active-line segment plus one grant.
- frame_tick: registered; asserted for 1 clk, the cycle after inputs show pixel_x==0 && pixel_y==VD. Exactly once per frame.
- Simultaneous window close and req: window is evaluated from the current-cycle video_on, so a req in the first ACTIVE cycle is not granted.
- Reset mid-write: the in-flight grant is dropped; the requester must re-request.

Optional Feature:
- Macro: VGA_FB_VBLANK_ONLY_EN
- Defined: write window = VBLANK only. HBLANK cycles give no grants, which prevents tearing within a frame.
- Undefined: window = HBLANK or VBLANK, as above.
- All other behaviour is identical.

Test Plan:
- Reset: assert rst mid-frame with w0_req=1 -> gnt=0, ram_we=0, rgb=0, hsync_o=1, vsync_o=1, video_on_o=0 immediately. After release, first tie grants w0.
- Scan addressing:
  - Full frame from timing model -> ram_addr=0 at (0,0), 639 at (639,0), 640 at (0,1), 307199 at (639,479).
  - ram_we=0 throughout ACTIVE.
  - rgb equals the RAM model's data 1 clk later.
- Blocking: w0_req=1 with addr 100 during ACTIVE -> no gnt until the first HBLANK cycle (pixel_x=640). Then w0_gnt=1, ram_we=1, ram_addr=100 in that same cycle.
- Round-robin: w0_req=w1_req=1 held through HBLANK -> grants w0,w1,w0,w1…. Four writes land at their respective addresses.
- Out-of-range: w1_addr=307200 in blank -> w1_gnt=1, ram_we=0. RAM unchanged.
- Macro and tick:
  - With VGA_FB_VBLANK_ONLY_EN, req during HBLANK of line 10 -> no gnt until pixel_y=480.
  - frame_tick pulses once, the cycle after (0,480), in both builds.

Source files
------------

// File: rtl/vga_fb_arbiter_if.sv
// rtl/vga_fb_arbiter_if.sv - writer request ports and framebuffer RAM bus for vga_fb_arbiter
interface vga_fb_arbiter_if #(
  parameter int AW = 19,
  parameter int DW = 12
);
  logic          w0_req;
  logic [AW-1:0] w0_addr;
  logic [DW-1:0] w0_data;
  logic          w0_gnt;
  logic          w1_req;
  logic [AW-1:0] w1_addr;
  logic [DW-1:0] w1_data;
  logic          w1_gnt;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  // master: the arbiter, which owns the RAM port and answers the writers
  modport master (
    input  w0_req, w0_addr, w0_data, w1_req, w1_addr, w1_data, ram_rdata,
    output w0_gnt, w1_gnt, ram_addr, ram_we, ram_wdata
  );

  modport slave (
    output w0_req, w0_addr, w0_data, w1_req, w1_addr, w1_data, ram_rdata,
    input  w0_gnt, w1_gnt, ram_addr, ram_we, ram_wdata
  );
endinterface

// File: rtl/vga_fb_arbiter.sv
// rtl/vga_fb_arbiter.sv - framebuffer RAM sharing between scanout and two writers
// Optional VGA_FB_VBLANK_ONLY_EN restricts the write window to vertical blank.
module vga_fb_arbiter #(
  parameter int HD = 640,
  parameter int VD = 480,
  parameter int AW = 19,
  parameter int DW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [11:0]   pixel_x,
  input  logic [11:0]   pixel_y,
  input  logic          video_on,
  input  logic          hsync,
  input  logic          vsync,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic          video_on_o,
  output logic [DW-1:0] rgb,
  output logic          frame_tick,
  vga_fb_arbiter_if.master bus
);
  localparam logic [11:0] VD_L   = 12'(VD);
  localparam logic [AW:0] NPIX_L = (AW+1)'(HD * VD);

  logic [AW-1:0] scan_addr;
  logic          rr_last;
  logic          vblank;
  logic          window;
  logic          w0_sel;
  logic          w1_sel;

  assign vblank = (pixel_y >= VD_L);

`ifdef VGA_FB_VBLANK_ONLY_EN
  assign window = vblank;
`else
  assign window = !video_on;
`endif

  // Tie goes to the writer that did not win the previous tie
  always_comb begin
    w0_sel = 1'b0;
    w1_sel = 1'b0;
    if (!rst && window) begin
      if (bus.w0_req && (!bus.w1_req || rr_last))
        w0_sel = 1'b1;
      else if (bus.w1_req)
        w1_sel = 1'b1;
    end
  end

  assign bus.w0_gnt = w0_sel;
  assign bus.w1_gnt = w1_sel;

  // Out-of-range writes still consume the request but never strobe the RAM
  always_comb begin
    bus.ram_addr  = scan_addr;
    bus.ram_we    = 1'b0;
    bus.ram_wdata = '0;
    if (w0_sel) begin
      bus.ram_addr  = bus.w0_addr;
      bus.ram_wdata = bus.w0_data;
      bus.ram_we    = ({1'b0, bus.w0_addr} < NPIX_L);
    end else if (w1_sel) begin
      bus.ram_addr  = bus.w1_addr;
      bus.ram_wdata = bus.w1_data;
      bus.ram_we    = ({1'b0, bus.w1_addr} < NPIX_L);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_addr  <= '0;
      rr_last    <= 1'b1;
      frame_tick <= 1'b0;
      hsync_o    <= 1'b1;
      vsync_o    <= 1'b1;
      video_on_o <= 1'b0;
    end else begin
      hsync_o    <= hsync;
      vsync_o    <= vsync;
      video_on_o <= video_on;
      frame_tick <= (pixel_x == 12'd0) && (pixel_y == VD_L);
      // Linear scan counter replaces y*HD+x; it restarts every vertical blank
      if (vblank)
        scan_addr <= '0;
      else if (video_on)
        scan_addr <= scan_addr + 1'b1;
      if (w0_sel && bus.w1_req)
        rr_last <= 1'b0;
      else if (w1_sel && bus.w0_req)
        rr_last <= 1'b1;
    end
  end

  assign rgb = video_on_o ? bus.ram_rdata : '0;
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb/tb_vga_fb_arbiter.sv - randomized scoreboard bench for vga_fb_arbiter
module tb_vga_fb_arbiter;
  localparam int HD    = 32;
  localparam int VD    = 12;
  localparam int AW    = 19;
  localparam int DW    = 12;
  localparam int H_TOT = 40;
  localparam int V_TOT = 16;
  localparam int NPIX  = HD * VD;
  localparam int FRAME = H_TOT * V_TOT;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [11:0]   px = '0;
  logic [11:0]   py = '0;
  logic          von = 1'b0;
  logic          hs = 1'b1;
  logic          vs = 1'b1;
  logic          hs_o;
  logic          vs_o;
  logic          von_o;
  logic          ftick;
  logic [DW-1:0] rgb;

  vga_fb_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  vga_fb_arbiter #(.HD(HD), .VD(VD), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .pixel_x(px), .pixel_y(py), .video_on(von), .hsync(hs), .vsync(vs),
    .hsync_o(hs_o), .vsync_o(vs_o), .video_on_o(von_o),
    .rgb(rgb), .frame_tick(ftick),
    .bus(bus)
  );

  always #20 clk = ~clk;

  // Physical RAM: synchronous read, one cycle latency
  logic [DW-1:0] ram [0:1023];
  always @(posedge clk) begin
    if (bus.ram_we && bus.ram_addr < 1024)
      ram[bus.ram_addr[9:0]] <= bus.ram_wdata;
    bus.ram_rdata <= (bus.ram_addr < 1024) ? ram[bus.ram_addr[9:0]] : '0;
  end

  // Reference model state
  logic [DW-1:0] ref_mem [0:NPIX-1];
  int            rr_model;
  logic [AW-1:0] exp_addr_q [$];
  logic [DW-1:0] exp_rgb_q [$];
  logic          p_hs = 1'b1, p_vs = 1'b1, p_von = 1'b0, p_tick = 1'b0;
  int            tests = 0, fails = 0;
  int            n_g0 = 0, n_g1 = 0, n_tick = 0;
  int            x = 0, y = 0;
  logic          pend0 = 1'b0, pend1 = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at x=%0d y=%0d t=%0t", name, act, exp, px, py, $time);
    end
  endtask

  logic          m_win, m_e0, m_e1;
  logic [AW-1:0] m_wa;
  logic [DW-1:0] m_wd;

  always @(negedge clk) begin
    if (rst) begin
      rr_model = 1;
      p_hs = 1'b1; p_vs = 1'b1; p_von = 1'b0; p_tick = 1'b0;
      exp_addr_q.delete();
      exp_rgb_q.delete();
    end else begin
`ifdef VGA_FB_VBLANK_ONLY_EN
      m_win = (py >= VD);
`else
      m_win = !von;
`endif
      m_e0 = m_win && bus.w0_req && (!bus.w1_req || rr_model == 1);
      m_e1 = m_win && bus.w1_req && !m_e0;
      check("w0_gnt", 32'(bus.w0_gnt), 32'(m_e0));
      check("w1_gnt", 32'(bus.w1_gnt), 32'(m_e1));
      if (m_e0 || m_e1) begin
        m_wa = m_e0 ? bus.w0_addr : bus.w1_addr;
        m_wd = m_e0 ? bus.w0_data : bus.w1_data;
        check("wr_addr", 32'(bus.ram_addr), 32'(m_wa));
        check("wr_we", 32'(bus.ram_we), 32'(m_wa < NPIX));
        if (m_wa < NPIX) begin
          check("wr_data", 32'(bus.ram_wdata), 32'(m_wd));
          ref_mem[m_wa] = m_wd;
        end
        if (bus.w0_req && bus.w1_req) rr_model = m_e0 ? 0 : 1;
        if (m_e0 && bus.w0_gnt) n_g0++;
        if (m_e1 && bus.w1_gnt) n_g1++;
      end else begin
        check("idle_we", 32'(bus.ram_we), 32'd0);
      end
      if (von) begin
        check("scan_q_depth", 32'(exp_addr_q.size()), 32'd1);
        if (exp_addr_q.size() > 0) check("scan_addr", 32'(bus.ram_addr), 32'(exp_addr_q.pop_front()));
      end
      if (von_o) begin
        check("rgb_q_nonempty", 32'(exp_rgb_q.size() > 0), 32'd1);
        if (exp_rgb_q.size() > 0) check("rgb", 32'(rgb), 32'(exp_rgb_q.pop_front()));
      end else begin
        check("rgb_blank", 32'(rgb), 32'd0);
      end
      check("hsync_o", 32'(hs_o), 32'(p_hs));
      check("vsync_o", 32'(vs_o), 32'(p_vs));
      check("video_on_o", 32'(von_o), 32'(p_von));
      check("frame_tick", 32'(ftick), 32'(p_tick));
      if (ftick) n_tick++;
      p_hs = hs; p_vs = vs; p_von = von;
      p_tick = (px == 0) && (py == VD);
    end
  end

  task automatic drive_timing();
    px  = 12'(x);
    py  = 12'(y);
    von = (x < HD) && (y < VD);
    hs  = !(x >= 34 && x < 38);
    vs  = !(y >= 13 && y < 15);
    if (von) begin
      exp_addr_q.push_back(AW'(y * HD + x));
      exp_rgb_q.push_back(ref_mem[y * HD + x]);
    end
  endtask

  task automatic new_req(input int id);
    int            r;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    r = $urandom_range(0, 7);
    if (r == 0)      a = AW'(NPIX);
    else if (r == 1) a = AW'(NPIX + $urandom_range(1, 50));
    else             a = AW'($urandom_range(0, NPIX - 1));
    d = DW'($urandom);
    if (id == 0) begin
      pend0 = 1'b1; bus.w0_addr = a; bus.w0_data = d; bus.w0_req = 1'b1;
    end else begin
      pend1 = 1'b1; bus.w1_addr = a; bus.w1_data = d; bus.w1_req = 1'b1;
    end
  endtask

  task automatic step();
    logic g0, g1;
    @(negedge clk);
    g0 = bus.w0_gnt;
    g1 = bus.w1_gnt;
    @(posedge clk);
    #1;
    if (g0) pend0 = 1'b0;
    if (g1) pend1 = 1'b0;
    if (!pend0 && $urandom_range(0, 3) != 0) new_req(0);
    if (!pend1 && $urandom_range(0, 3) != 0) new_req(1);
    bus.w0_req = pend0;
    bus.w1_req = pend1;
    x++;
    if (x == H_TOT) begin
      x = 0;
      y++;
      if (y == V_TOT) y = 0;
    end
    drive_timing();
  endtask

  task automatic start_frame();
    @(posedge clk);
    #1;
    rst = 1'b0;
    x = 0;
    y = 0;
    drive_timing();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = '0;
    for (int i = 0; i < NPIX; i++) ref_mem[i] = '0;
    bus.w0_req = 1'b0; bus.w0_addr = '0; bus.w0_data = '0;
    bus.w1_req = 1'b0; bus.w1_addr = '0; bus.w1_data = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    start_frame();
    repeat (2 * FRAME) step();

    // Async reset on the first blanking cycle of a line, with writer 0 requesting
    do step(); while (!(x == HD && y == 5));
    if (!pend0) new_req(0);
    bus.w0_req = 1'b1;
    rst = 1'b1;
    #1;
    check("rst_w0_gnt", 32'(bus.w0_gnt), 32'd0);
    check("rst_ram_we", 32'(bus.ram_we), 32'd0);
    check("rst_rgb", 32'(rgb), 32'd0);
    check("rst_hsync_o", 32'(hs_o), 32'd1);
    check("rst_vsync_o", 32'(vs_o), 32'd1);
    check("rst_video_on_o", 32'(von_o), 32'd0);
    check("rst_frame_tick", 32'(ftick), 32'd0);
    if (!pend1) new_req(1);
    repeat (3) @(posedge clk);
    start_frame();
    repeat (2 * FRAME + 100) step();

    check("w0_granted_some", 32'(n_g0 > 0), 32'd1);
    check("w1_granted_some", 32'(n_g1 > 0), 32'd1);
    check("ticks_seen", 32'(n_tick >= 3), 32'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
